// File: rtl/snd_pkg.sv
// snd_pkg: shared state encoding, tone codes and small helpers for the
// sound event arbiter.
package snd_pkg;

    localparam int NUM_SRC = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } snd_state_t;

    localparam logic [2:0] TONE_OFF  = 3'd0;
    localparam logic [2:0] TONE_SHOT = 3'd1;
    localparam logic [2:0] TONE_INV  = 3'd2;
    localparam logic [2:0] TONE_PLR  = 3'd3;
    localparam logic [2:0] TONE_OVER = 3'd4;

    // Tone code a source plays while it owns the I2S player.
    function automatic logic [2:0] tone_of(input logic [1:0] src);
        logic [2:0] code;
        case (src)
            2'd0:    code = TONE_SHOT;
            2'd1:    code = TONE_INV;
            2'd2:    code = TONE_PLR;
            default: code = TONE_OVER;
        endcase
        return code;
    endfunction

    // Number of set bits in a 4-bit request vector.
    function automatic logic [2:0] pop4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/snd_pri_enc4.sv
// snd_pri_enc4: fixed-priority encoder, bit 3 wins. Gives a valid flag,
// the winning index and the same winner as a one-hot vector.
module snd_pri_enc4 (
    input  logic [3:0] request,
    output logic       valid,
    output logic [1:0] index,
    output logic [3:0] onehot
);

    // Pick the highest set request bit.
    always_comb begin
        valid  = |request;
        index  = 2'd0;
        onehot = 4'b0000;
        if (request[3]) begin
            index  = 2'd3;
            onehot = 4'b1000;
        end else if (request[2]) begin
            index  = 2'd2;
            onehot = 4'b0100;
        end else if (request[1]) begin
            index  = 2'd1;
            onehot = 4'b0010;
        end else if (request[0]) begin
            index  = 2'd0;
            onehot = 4'b0001;
        end
    end

endmodule

// File: rtl/sound_event_arbiter.sv
// sound_event_arbiter: shares the tone player between four game events.
// Requests are latched as pending, granted one at a time by fixed priority,
// played for a per-source duration and followed by a forced silent gap.
// Optional build macro SND_PREEMPT_EN lets a higher-priority pending request
// cut a playing sound short (the cut sound is counted in dropped).
module sound_event_arbiter
    import snd_pkg::*;
#(
    parameter int unsigned DUR0    = 5000000,
    parameter int unsigned DUR1    = 10000000,
    parameter int unsigned DUR2    = 20000000,
    parameter int unsigned DUR3    = 50000000,
    parameter int unsigned GAP_CYC = 1000000,
    parameter int          CNT_W   = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic               mute,
    output logic [2:0]         tone,
    output logic [NUM_SRC-1:0] grant,
    output logic               busy,
    output logic [7:0]         dropped
);

    // Counter reload value for a length in cycles; a length of 0 acts as 1.
    function automatic logic [CNT_W-1:0] load_of(input int unsigned cycles);
        return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
    endfunction

    function automatic logic [CNT_W-1:0] dur_load(input logic [1:0] src);
        logic [CNT_W-1:0] v;
        case (src)
            2'd0:    v = load_of(DUR0);
            2'd1:    v = load_of(DUR1);
            2'd2:    v = load_of(DUR2);
            default: v = load_of(DUR3);
        endcase
        return v;
    endfunction

    localparam logic [CNT_W-1:0] GAP_LOAD = load_of(GAP_CYC);

    snd_state_t         state;
    logic [CNT_W-1:0]   counter;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] coalesce;
    logic               enc_valid;
    logic [1:0]         enc_idx;
    logic [NUM_SRC-1:0] enc_onehot;
    logic               start_idle;
    logic               preempt;
    logic               take;
    logic [2:0]         drop_inc;
    logic [8:0]         drop_sum;
    logic [7:0]         dropped_next;
`ifdef SND_PREEMPT_EN
    logic [1:0]         cur_src;
`endif

    // One encoder on the pending vector serves both the idle grant and the
    // preemption compare.
    snd_pri_enc4 u_enc (
        .request (pending),
        .valid   (enc_valid),
        .index   (enc_idx),
        .onehot  (enc_onehot)
    );

    // Decide whether a source is taken this edge and what pending/dropped become.
    always_comb begin
        start_idle = (state == IDLE) && enc_valid && !mute;
`ifdef SND_PREEMPT_EN
        preempt = (state == PLAY) && enc_valid && (enc_idx > cur_src) && !mute;
`else
        preempt = 1'b0;
`endif
        take     = start_idle || preempt;
        clr_mask = take ? enc_onehot : '0;
        coalesce = req & pending & ~clr_mask;
        if (mute) begin
            pending_next = '0;
            drop_inc     = pop4(req);
        end else begin
            pending_next = (pending & ~clr_mask) | req;
            drop_inc     = pop4(coalesce) + {2'b00, preempt};
        end
        drop_sum     = {1'b0, dropped} + {6'b000000, drop_inc};
        dropped_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Pending latch and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            dropped <= '0;
        end else begin
            pending <= pending_next;
            dropped <= dropped_next;
        end
    end

    // IDLE/PLAY/GAP sequencer with registered tone, grant and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            tone    <= TONE_OFF;
            grant   <= '0;
            busy    <= 1'b0;
`ifdef SND_PREEMPT_EN
            cur_src <= 2'd0;
`endif
        end else begin
            grant <= '0;
            if (mute) begin
                state   <= IDLE;
                counter <= '0;
                tone    <= TONE_OFF;
                busy    <= 1'b0;
            end else if (take) begin
                state   <= PLAY;
                counter <= dur_load(enc_idx);
                tone    <= tone_of(enc_idx);
                grant   <= enc_onehot;
                busy    <= 1'b1;
`ifdef SND_PREEMPT_EN
                cur_src <= enc_idx;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    PLAY: begin
                        if (counter == '0) begin
                            state   <= GAP;
                            tone    <= TONE_OFF;
                            counter <= GAP_LOAD;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    GAP: begin
                        if (counter == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        counter <= '0;
                        tone    <= TONE_OFF;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// tb_sound_event_arbiter: randomized and directed stimulus for the sound
// event arbiter, checked cycle by cycle against a timeline reference model
// through an expectation queue drained by an independent monitor.
module tb_sound_event_arbiter;

    localparam int GAP = 3;
    int dur_tab [4] = '{4, 6, 8, 10};

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       mute;
    logic [2:0] tone;
    logic [3:0] grant;
    logic       busy;
    logic [7:0] dropped;

    typedef struct {
        logic [2:0] tone;
        logic [3:0] grant;
        logic       busy;
        logic [7:0] dropped;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: pending bits plus the edge number of the last grant.
    int       m_t      = 0;
    bit [3:0] m_pend   = '0;
    bit       m_active = 1'b0;
    int       m_tg     = 0;
    int       m_src    = 0;
    int       m_drop   = 0;

    logic [3:0] rnd_req;
    logic       rnd_rst;
    logic       mute_lvl;

    sound_event_arbiter #(
        .DUR0    (4),
        .DUR1    (6),
        .DUR2    (8),
        .DUR3    (10),
        .GAP_CYC (GAP),
        .CNT_W   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .mute    (mute),
        .tone    (tone),
        .grant   (grant),
        .busy    (busy),
        .dropped (dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    // Advance the model by one clock edge and produce the outputs expected after it.
    task automatic model_step(input logic [3:0] r, input logic m, input logic rs, output exp_t e);
        int  ph;
        int  g;
        int  d;
        bit  take;
        m_t++;
        e.cyc   = m_t;
        e.grant = 4'b0000;
        if (rs) begin
            m_pend   = '0;
            m_active = 1'b0;
            m_drop   = 0;
        end else if (m) begin
            for (int i = 0; i < 4; i++) if (r[i]) m_drop = sat_add(m_drop, 1);
            m_pend   = '0;
            m_active = 1'b0;
        end else begin
            ph = 0;
            if (m_active) begin
                d = dur_tab[m_src];
                if (m_t > m_tg && m_t <= m_tg + d) ph = 1;
                else if (m_t > m_tg + d && m_t <= m_tg + d + GAP) ph = 2;
            end
            g = -1;
            for (int i = 0; i < 4; i++) if (m_pend[i]) g = i;
            take = (g >= 0) && (ph == 0);
`ifdef SND_PREEMPT_EN
            if ((g >= 0) && (ph == 1) && (g > m_src)) begin
                take   = 1'b1;
                m_drop = sat_add(m_drop, 1);
            end
`endif
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    if (m_pend[i] && !(take && g == i)) m_drop = sat_add(m_drop, 1);
                    m_pend[i] = 1'b1;
                end else if (take && g == i) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (take) begin
                m_active = 1'b1;
                m_tg     = m_t;
                m_src    = g;
                e.grant  = 4'(1 << g);
            end
        end
        e.tone    = 3'd0;
        e.busy    = 1'b0;
        if (m_active && m_t >= m_tg && m_t < m_tg + dur_tab[m_src])
            e.tone = 3'(m_src + 1);
        if (m_active && m_t >= m_tg && m_t < m_tg + dur_tab[m_src] + GAP)
            e.busy = 1'b1;
        e.dropped = 8'(m_drop);
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic applyStimulus(input logic [3:0] r, input logic m, input logic rs);
        exp_t e;
        @(negedge clk);
        req   = r;
        mute  = m;
        reset = rs;
        model_step(r, m, rs, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
    endtask

    // Monitor: after every edge compare the DUT against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput($sformatf("tone@%0d", mon_e.cyc), 32'(tone), 32'(mon_e.tone));
                checkOutput($sformatf("grant@%0d", mon_e.cyc), 32'(grant), 32'(mon_e.grant));
                checkOutput($sformatf("busy@%0d", mon_e.cyc), 32'(busy), 32'(mon_e.busy));
                checkOutput($sformatf("dropped@%0d", mon_e.cyc), 32'(dropped), 32'(mon_e.dropped));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, saturation burst, then randomized traffic.
    initial begin
        reset    = 1'b1;
        req      = 4'b0000;
        mute     = 1'b0;
        mute_lvl = 1'b0;

        // Single shot from idle.
        doReset();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        idle(12);
        checkOutput("t1 dropped", 32'(dropped), 32'd0);
        checkOutput("t1 busy idle", 32'(busy), 32'd0);

        // Two sources on the same edge: priority order, nothing dropped.
        doReset();
        applyStimulus(4'b0101, 1'b0, 1'b0);
        idle(26);
        checkOutput("t2 dropped", 32'(dropped), 32'd0);

        // Repeated shot requests during a game-over play coalesce.
        doReset();
        applyStimulus(4'b1000, 1'b0, 1'b0);
        idle(2);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        idle(1);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        idle(1);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        idle(20);
        checkOutput("t3 dropped", 32'(dropped), 32'd2);

        // Mute mid-play clears pending; a muted request is dropped.
        doReset();
        applyStimulus(4'b0100, 1'b0, 1'b0);
        idle(2);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        idle(5);
        checkOutput("t4 dropped", 32'(dropped), 32'd1);
        checkOutput("t4 tone", 32'(tone), 32'd0);
        checkOutput("t4 busy", 32'(busy), 32'd0);

        // Request on the same edge as its own grant survives.
        doReset();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        idle(20);
        checkOutput("t5 dropped", 32'(dropped), 32'd0);

        // Game over arriving during a shot play.
        doReset();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        idle(2);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        idle(24);
`ifdef SND_PREEMPT_EN
        checkOutput("t6 dropped", 32'(dropped), 32'd1);
`else
        checkOutput("t6 dropped", 32'(dropped), 32'd0);
`endif

        // Drop counter saturation.
        doReset();
        for (int i = 0; i < 70; i++) applyStimulus(4'b1111, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        idle(1);
        checkOutput("t7 dropped sat", 32'(dropped), 32'd255);

        // Randomized traffic with occasional mute bursts and resets.
        doReset();
        for (int n = 0; n < 800; n++) begin
            rnd_req = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            if (mute_lvl) begin
                if ($urandom_range(0, 7) == 0) mute_lvl = 1'b0;
            end else begin
                if ($urandom_range(0, 79) == 0) mute_lvl = 1'b1;
            end
            rnd_rst = ($urandom_range(0, 299) == 0);
            applyStimulus(rnd_req, mute_lvl, rnd_rst);
        end
        idle(2);
        @(posedge clk);
        #2;
        checkOutput("queue drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
